// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared constants and helpers for the pipelined logic unit.
//   - opcode width and opcode encodings
//   - popcount / parity helpers used by the flag stage
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_ANDN = 3'd7;

  // Widest operand the helpers accept; callers zero-extend into this.
  localparam int POP_MAX_W = 256;

  // Counts the 1 bits in the low 'width' bits of v.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v,
                                           input int unsigned width);
    int unsigned cnt;
    cnt = 32'd0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (i < width) begin
        cnt = cnt + {31'd0, v[i]};
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  // Odd parity (XOR reduction); zero padding does not change the result.
  function automatic logic parity_of(input logic [POP_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_op_core.sv
// logic_op_core: combinational bitwise operator.
//   op     : operation select (see logic_unit_pkg opcodes)
//   a, b   : WIDTH-bit operands (b unused for NOT)
//   result : WIDTH-bit bitwise result
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Opcode decode to the selected bitwise function.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      OP_ANDN: result = a & ~b;
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with result flags.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand beat handshake (op, a, b)
//   out_valid/out_ready : result beat handshake (result, zero, parity, ones)
// S1 registers the bitwise result; S2 registers it again together with the
// flags derived from it, so result and flags always belong to the same beat.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] ones
);

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_result_q, s1_result_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 parity_q, parity_d;
  logic [CNT_W-1:0]     ones_q, ones_d;

  logic [WIDTH-1:0]     core_result;
  logic                 s2_can_load;
  logic                 s1_can_load;
  logic                 in_hs;
  logic                 s2_load;
  logic [POP_MAX_W-1:0] pop_in;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (core_result)
  );

  // S2 frees up when empty or draining; S1 frees up when empty or moving to S2.
  assign s2_can_load = !out_valid_q || out_ready;
  assign s1_can_load = !s1_valid_q || s2_can_load;
  assign in_ready    = s1_can_load;
  assign in_hs       = in_valid && s1_can_load;
  assign s2_load     = s2_can_load && s1_valid_q;

  // S1 next state: valid follows in_valid whenever the slot is free.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_result_d = s1_result_q;
    if (s1_can_load) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_hs) begin
      s1_result_d = core_result;
    end else begin
      s1_result_d = s1_result_q;
    end
  end

  // S2 next state: result and flags load together from the S1 result.
  always_comb begin
    pop_in              = {POP_MAX_W{1'b0}};
    pop_in[WIDTH-1:0]   = s1_result_q;
    out_valid_d         = out_valid_q;
    result_d            = result_q;
    zero_d              = zero_q;
    parity_d            = parity_q;
    ones_d              = ones_q;
    if (s2_can_load) begin
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (s2_load) begin
      result_d = s1_result_q;
      zero_d   = (s1_result_q == {WIDTH{1'b0}});
      parity_d = parity_of(pop_in);
      ones_d   = CNT_W'(popcount(pop_in, WIDTH));
    end else begin
      result_d = result_q;
      zero_d   = zero_q;
      parity_d = parity_q;
      ones_d   = ones_q;
    end
  end

  // Pipeline registers; zero resets high to match the all-zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      ones_q      <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_result_q <= s1_result_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      ones_q      <= ones_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign ones      = ones_q;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8-bit bitwise AND.
- Applies one of eight bitwise operations to two WIDTH-bit operands and produces three result flags: zero, parity and ones count.
- Valid/ready handshakes on input and output allow the block to sit between the ALU operand-select logic and the result/flag writeback.
- Sustains one operation per cycle, with two-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH+1), width of the ones-count output. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- op  in  3  operation select, per the opcode list below.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  bitwise result.
- zero  out  1  high when result is all zeros.
- parity  out  1  XOR reduction of result (odd parity).
- ones  out  CNT_W  number of 1 bits in result.

Behaviour:
- Opcodes:
  - 0 AND: a&b.
  - 1 OR.
  - 2 XOR.
  - 3 NAND.
  - 4 NOR.
  - 5 XNOR.
  - 6 NOT: ~a; b is ignored.
  - 7 ANDN: a&~b.
- Stage 1 (S1):
  - On an input handshake (in_valid & in_ready), registers the bitwise result of op/a/b and sets s1_valid.
- Stage 2 (S2):
  - Registers the S1 result and computes zero, parity and ones from the S1 result.
  - Sets out_valid.
  - result and all flags in S2 always correspond to the same beat.
- Pipeline advance:
  - S2 loads when S2 is empty or (out_valid & out_ready).
  - S1 loads when S1 is empty or S1 is transferring into S2.
  - in_ready = !s1_valid | s2_can_load.
  - in_ready is combinational from out_ready and the valid bits only.
- Latency and throughput:
  - With out_ready held high, a beat accepted at edge N is presented at out_valid after edge N+1, i.e. during cycle N+1 to N+2.
  - Throughput is one beat per cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, result/zero/parity/ones hold stable.
  - S1 still fills if it is empty; in_ready then deasserts.
  - At most 2 beats are in flight; no beat is ever dropped or duplicated.
- Simultaneous events:
  - When S2 drains and S1 moves into S2 in the same cycle, a new input is accepted into S1 in that cycle as well.
  - in_valid=0 while S1 drains clears s1_valid.
- Input data:
  - Inputs are sampled only on a handshake.
  - Changes to a/b/op while in_valid=0 or in_ready=0 have no effect.
- Reset:
  - Asynchronous on rst_n low. s1_valid, out_valid, result, ones and parity all go to 0. zero resets to 1, consistent with result=0.
  - in_ready is 1 after reset.
  - Reset mid-operation discards every in-flight beat; nothing is emitted afterwards for those beats.
- Arithmetic:
  - All operations are purely bitwise, with no carries.
  - ones is a full popcount, from 0 to WIDTH; WIDTH fits in CNT_W.

Decomposition:
- Package logic_unit_pkg holds:
  - the opcode localparams (OP_AND=3'd0 … OP_ANDN=3'd7);
  - the opcode width constant;
  - a popcount function parametrised by width.
- Sub-module logic_op_core: combinational, WIDTH-parametrised; inputs op/a/b, output result. Instantiated in S1.
- The handshake and flag registers stay in logic_unit_pipe.

Test Plan:
- Reset with WIDTH=8:
  - Assert rst_n=0 mid-stream, then release → out_valid=0, result=0, zero=1, ones=0, in_ready=1.
  - No stale beat appears afterwards.
- All opcodes, WIDTH=8, a=8'hC5, b=8'h3A, out_ready=1 → results in order FF?no:
  - AND=00 (zero=1, ones=0).
  - OR=FF (ones=8, parity=0).
  - XOR=FF.
  - NAND=FF.
  - NOR=00.
  - XNOR=00.
  - NOT=3A (ones=4).
  - ANDN=C5 (ones=4, parity=0).
  - Each result appears 2 cycles after its handshake.
- Back-to-back streaming:
  - 16 consecutive beats of random a/b/op with out_ready=1 → 16 results, in order, on 16 consecutive cycles.
  - Each result matches the reference model.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while in_valid=1 → in_ready drops after 2 accepts.
  - result holds stable for the whole stall.
  - On release, both beats drain in order with no loss.
- Simultaneous drain and accept:
  - With both stages full, toggle out_ready 1/0 every cycle → one accept per drain cycle.
  - Output sequence equals input sequence.
- Width generality, WIDTH=13, OR of a=13'h1FFF, b=0 → result=1FFF, ones=13 (CNT_W=4), parity=1, zero=0.
